// File: rtl/ddr_rd_pkg.sv
// Shared types and constants for the DDR line-read burst engine.
package ddr_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  localparam int AXI_LEN_W    = 8;
  localparam int DDR_DQ_WIDTH = 32;

  // A beat is 8*DQ bits; addresses count 32-bit words.
  function automatic int words_per_beat(input int dq_width);
    return (8 * dq_width) / 32;
  endfunction

  localparam int BEAT_ADDR_INC = words_per_beat(DDR_DQ_WIDTH);

endpackage

// File: rtl/rd_burst_ctrl_req_slot.sv
// One-deep pending request register; a push into a full slot that is not
// being drained in the same cycle is dropped and flagged sticky.
module rd_req_slot
  import ddr_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [LEN_WIDTH-1:0]  i_len,
  input  logic                  i_pop,
  output logic                  o_full,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [LEN_WIDTH-1:0]  o_len,
  output logic                  o_overflow
);

  logic                  r_full;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic                  r_overflow;
  logic                  w_load;
  logic                  w_drop;

  // A pop frees the slot this cycle, so a simultaneous push may refill it.
  assign w_load = i_push & (~r_full | i_pop);
  assign w_drop = i_push & r_full & ~i_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full     <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_load) begin
        r_full <= 1'b1;
        r_addr <= i_addr;
        r_len  <= i_len;
      end else if (i_pop) begin
        r_full <= 1'b0;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_full     = r_full;
  assign o_addr     = r_addr;
  assign o_len      = r_len;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/rd_burst_ctrl.sv
// DDR line-read engine: splits a line request into AXI4 read bursts and
// streams the returned beats to the line cell with a one-cycle latency.
module rd_burst_ctrl
  import ddr_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 27,
  parameter int DQ_WIDTH   = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int BURST_MAX  = 16
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    ddr_rreq,
  input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
  input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
  output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  output logic                    ddr_rdata_en,
  output logic                    ddr_rdone,
  output logic                    busy,
  output logic                    err_overflow,
  output logic                    err_rlast,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [AXI_LEN_W-1:0]    axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
);

  rd_state_e               r_state;
  logic [ADDR_WIDTH-1:0]   r_cur_addr;
  logic [LEN_WIDTH-1:0]    r_remain;
  logic [AXI_LEN_W:0]      r_beats;
  logic [AXI_LEN_W:0]      r_beat_cnt;
  logic [ADDR_WIDTH-1:0]   r_araddr;
  logic [AXI_LEN_W-1:0]    r_arlen;
  logic                    r_arvalid;
  logic                    r_rready;
  logic [8*DQ_WIDTH-1:0]   r_rdata;
  logic                    r_rdata_en;
  logic                    r_rdone;
  logic                    r_err_rlast;

  logic                    w_idle;
  logic                    w_slot_full;
  logic [ADDR_WIDTH-1:0]   w_slot_addr;
  logic [LEN_WIDTH-1:0]    w_slot_len;
  logic                    w_slot_ovf;
  logic                    w_slot_push;
  logic                    w_slot_pop;
  logic                    w_start;
  logic [ADDR_WIDTH-1:0]   w_start_addr;
  logic [LEN_WIDTH-1:0]    w_start_len;
  logic                    w_beat;
  logic                    w_last_beat;
  logic [ADDR_WIDTH-1:0]   w_addr_nxt;
  logic [LEN_WIDTH-1:0]    w_remain_nxt;

  function automatic logic [AXI_LEN_W-1:0] burst_len_m1(input logic [LEN_WIDTH-1:0] rem);
    if (32'(rem) >= BURST_MAX) begin
      return AXI_LEN_W'(BURST_MAX - 1);
    end
    return AXI_LEN_W'(rem - LEN_WIDTH'(1));
  endfunction

  // A request is taken directly only when idle with nothing waiting;
  // otherwise it is offered to the pending slot, which is served first.
  assign w_idle       = (r_state == ST_IDLE);
  assign w_slot_pop   = w_idle & w_slot_full;
  assign w_slot_push  = ddr_rreq & ~(w_idle & ~w_slot_full);
  assign w_start      = w_idle & (ddr_rreq | w_slot_full);
  assign w_start_addr = w_slot_full ? w_slot_addr : ddr_raddr;
  assign w_start_len  = w_slot_full ? w_slot_len  : ddr_rd_len;

  rd_req_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_slot (
    .clk        (ddr_clk),
    .rst_n      (ddr_rstn),
    .i_push     (w_slot_push),
    .i_addr     (ddr_raddr),
    .i_len      (ddr_rd_len),
    .i_pop      (w_slot_pop),
    .o_full     (w_slot_full),
    .o_addr     (w_slot_addr),
    .o_len      (w_slot_len),
    .o_overflow (w_slot_ovf)
  );

  // The beat counter, not axi_rlast, decides where a burst ends.
  assign w_beat       = r_rready & axi_rvalid;
  assign w_last_beat  = (r_beat_cnt == (r_beats - (AXI_LEN_W+1)'(1)));
  assign w_addr_nxt   = r_cur_addr + ADDR_WIDTH'(r_beats) * ADDR_WIDTH'(BEAT_ADDR_INC);
  assign w_remain_nxt = r_remain - LEN_WIDTH'(r_beats);

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      r_state     <= ST_IDLE;
      r_cur_addr  <= '0;
      r_remain    <= '0;
      r_beats     <= '0;
      r_beat_cnt  <= '0;
      r_araddr    <= '0;
      r_arlen     <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rdata     <= '0;
      r_rdata_en  <= 1'b0;
      r_rdone     <= 1'b0;
      r_err_rlast <= 1'b0;
    end else begin
      r_rdata_en <= 1'b0;
      r_rdone    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cur_addr <= w_start_addr;
            r_remain   <= w_start_len;
            if (w_start_len == '0) begin
              r_state <= ST_DONE;
            end else begin
              r_state   <= ST_ADDR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_start_addr;
              r_arlen   <= burst_len_m1(w_start_len);
            end
          end
        end
        ST_ADDR: begin
          if (axi_arready) begin
            r_arvalid  <= 1'b0;
            r_beats    <= {1'b0, r_arlen} + (AXI_LEN_W+1)'(1);
            r_beat_cnt <= '0;
            r_rready   <= 1'b1;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_beat) begin
            r_rdata    <= axi_rdata;
            r_rdata_en <= 1'b1;
            if (axi_rlast != w_last_beat) begin
              r_err_rlast <= 1'b1;
            end
            if (w_last_beat) begin
              r_rready   <= 1'b0;
              r_cur_addr <= w_addr_nxt;
              r_remain   <= w_remain_nxt;
              if (w_remain_nxt != '0) begin
                r_state   <= ST_ADDR;
                r_arvalid <= 1'b1;
                r_araddr  <= w_addr_nxt;
                r_arlen   <= burst_len_m1(w_remain_nxt);
              end else begin
                r_state <= ST_DONE;
              end
            end else begin
              r_beat_cnt <= r_beat_cnt + (AXI_LEN_W+1)'(1);
            end
          end
        end
        // The final rdata_en was issued last cycle, so rdone lands just after it.
        ST_DONE: begin
          r_rdone <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ddr_rdata    = r_rdata;
  assign ddr_rdata_en = r_rdata_en;
  assign ddr_rdone    = r_rdone;
  assign busy         = ~w_idle | w_slot_full;
  assign err_overflow = w_slot_ovf;
  assign err_rlast    = r_err_rlast;
  assign axi_araddr   = r_araddr;
  assign axi_arlen    = r_arlen;
  assign axi_arvalid  = r_arvalid;
  assign axi_rready   = r_rready;

endmodule

// File: tb/tb_rd_burst_ctrl.sv
// Bench for rd_burst_ctrl: AXI slave responder, request-level reference model
// and a per-cycle compare process, driven by directed scenarios.
module tb_rd_burst_ctrl;

  localparam int AW = 27;
  localparam int DQ = 32;
  localparam int LW = 16;
  localparam int BM = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rreq = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [LW-1:0] rlen = '0;
  logic [255:0]  rdata;
  logic          rdata_en, rdone, busy, err_ovf, err_rl;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          arvalid, rready;
  logic          arready = 1'b0;
  logic [255:0]  axi_rdata = '0;
  logic          rvalid = 1'b0;
  logic          rlast = 1'b0;

  rd_burst_ctrl #(.ADDR_WIDTH(AW), .DQ_WIDTH(DQ), .LEN_WIDTH(LW), .BURST_MAX(BM)) dut (
    .ddr_clk(clk), .ddr_rstn(rstn), .ddr_rreq(rreq), .ddr_raddr(raddr),
    .ddr_rd_len(rlen), .ddr_rdata(rdata), .ddr_rdata_en(rdata_en),
    .ddr_rdone(rdone), .busy(busy), .err_overflow(err_ovf), .err_rlast(err_rl),
    .axi_araddr(araddr), .axi_arlen(arlen), .axi_arvalid(arvalid),
    .axi_arready(arready), .axi_rdata(axi_rdata), .axi_rvalid(rvalid),
    .axi_rlast(rlast), .axi_rready(rready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [255:0]  exp_data[$];
  logic [AW-1:0] exp_ar_addr[$];
  logic [7:0]    exp_ar_len[$];
  int            req_len_q[$];
  logic [AW-1:0] bq_addr[$];
  int            bq_len[$];
  logic [AW-1:0] ar_log_addr[$];
  logic [7:0]    ar_log_len[$];

  int delivered = 0, rdone_cnt = 0, beats_total = 0, rb = 0;
  int ar_wait = 0, ar_stall = 0, bad_rlast = -1;
  bit rv_toggle = 0, rv_phase = 0, r_hs_prev = 0, ar_hs_prev = 0, prev_arvalid = 0;
  logic [AW-1:0] prev_araddr = '0;
  logic [7:0]    prev_arlen = '0;

  function automatic logic [255:0] mk_data(input logic [AW-1:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) begin
      d[32*i +: 32] = {5'b0, a} ^ 32'(32'h9E3779B9 * 32'(i + 1));
    end
    return d;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a request is a run of beats at start+8k, cut into
  // bursts of at most BM beats.
  task automatic req(input logic [AW-1:0] a, input int n, input bit drop);
    logic [AW-1:0] ad;
    int rem, b;
    @(posedge clk); #1;
    rreq = 1'b1; raddr = a; rlen = LW'(n);
    if (!drop) begin
      for (int k = 0; k < n; k++) exp_data.push_back(mk_data(a + AW'(8 * k)));
      ad = a; rem = n;
      while (rem > 0) begin
        b = (rem < BM) ? rem : BM;
        exp_ar_addr.push_back(ad);
        exp_ar_len.push_back(8'(b - 1));
        ad = ad + AW'(8 * b);
        rem = rem - b;
      end
      req_len_q.push_back(n);
    end
    @(posedge clk); #1;
    rreq = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while ((busy || req_len_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 256'(n < budget), 256'(1));
  endtask

  // Compare process and AXI slave; outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rstn) begin
      exp_data.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
      req_len_q.delete(); bq_addr.delete(); bq_len.delete();
      arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      rb = 0; ar_wait = 0; delivered = 0;
      r_hs_prev = 0; ar_hs_prev = 0; prev_arvalid = 0;
    end else begin
      chk("rdata_en", 256'(rdata_en), 256'(r_hs_prev));
      if (rdata_en) begin
        if (exp_data.size() == 0) chk("rdata_extra", 256'(1), 256'(0));
        else chk("rdata", rdata, exp_data.pop_front());
        delivered++;
        beats_total++;
      end
      if (rdone) begin
        chk("rdone_vs_en", 256'(rdata_en), 256'(0));
        if (req_len_q.size() == 0) chk("rdone_extra", 256'(1), 256'(0));
        else chk("rdone_len", 256'(delivered), 256'(req_len_q.pop_front()));
        delivered = 0;
        rdone_cnt++;
      end
      if (arvalid && prev_arvalid && !ar_hs_prev) begin
        chk("ar_addr_stable", 256'(araddr), 256'(prev_araddr));
        chk("ar_len_stable", 256'(arlen), 256'(prev_arlen));
      end
      prev_arvalid = arvalid; prev_araddr = araddr; prev_arlen = arlen;

      if (arvalid) begin
        if (ar_wait < ar_stall) begin
          arready = 1'b0;
          ar_wait++;
        end else begin
          arready = 1'b1;
        end
      end else begin
        arready = 1'b0;
      end
      ar_hs_prev = arvalid && arready;
      if (ar_hs_prev) begin
        ar_wait = 0;
        ar_log_addr.push_back(araddr);
        ar_log_len.push_back(arlen);
        if (exp_ar_addr.size() == 0) begin
          chk("ar_extra", 256'(1), 256'(0));
        end else begin
          chk("ar_addr", 256'(araddr), 256'(exp_ar_addr.pop_front()));
          chk("ar_len", 256'(arlen), 256'(exp_ar_len.pop_front()));
        end
        bq_addr.push_back(araddr);
        bq_len.push_back(int'(arlen) + 1);
      end

      if (bq_len.size() > 0) begin
        rv_phase  = ~rv_phase;
        rvalid    = rv_toggle ? rv_phase : 1'b1;
        axi_rdata = mk_data(bq_addr[0] + AW'(8 * rb));
        rlast     = (rb == bq_len[0] - 1) || (rb == bad_rlast);
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
      end
      r_hs_prev = rvalid && rready;
      if (r_hs_prev) begin
        rb++;
        if (rb == bq_len[0]) begin
          void'(bq_addr.pop_front());
          void'(bq_len.pop_front());
          rb = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0;
    #1;
    chk("rst_rdata_en", 256'(rdata_en), 256'(0));
    chk("rst_rdone", 256'(rdone), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_arvalid", 256'(arvalid), 256'(0));
    chk("rst_rready", 256'(rready), 256'(0));
    chk("rst_rdata", rdata, 256'(0));
    chk("rst_flags", 256'({err_ovf, err_rl}), 256'(0));
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Full line: 180 beats from 0x100.
    ar_log_addr.delete(); ar_log_len.delete();
    b0 = beats_total; d0 = rdone_cnt;
    req(27'h100, 180, 0);
    wait_idle(2000, "full_done");
    chk("full_nbursts", 256'(ar_log_addr.size()), 256'(12));
    if (ar_log_addr.size() == 12) begin
      chk("full_ar0_addr", 256'(ar_log_addr[0]), 256'(27'h100));
      chk("full_ar0_len", 256'(ar_log_len[0]), 256'(15));
      chk("full_ar10_len", 256'(ar_log_len[10]), 256'(15));
      chk("full_ar11_addr", 256'(ar_log_addr[11]), 256'(27'h680));
      chk("full_ar11_len", 256'(ar_log_len[11]), 256'(3));
    end
    chk("full_beats", 256'(beats_total - b0), 256'(180));
    chk("full_rdones", 256'(rdone_cnt - d0), 256'(1));

    // Zero length: rdone two cycles after the strobe, no AR.
    ar_log_addr.delete(); ar_log_len.delete();
    @(posedge clk); #1;
    rreq = 1'b1; raddr = 27'h1234; rlen = '0;
    req_len_q.push_back(0);
    @(posedge clk); #1;
    rreq = 1'b0;
    chk("zl_rdone_c1", 256'(rdone), 256'(0));
    @(posedge clk); #1;
    chk("zl_rdone_c2", 256'(rdone), 256'(1));
    @(posedge clk); #1;
    chk("zl_rdone_c3", 256'(rdone), 256'(0));
    chk("zl_no_ar", 256'(ar_log_addr.size()), 256'(0));
    wait_idle(50, "zl_done");

    // Back-pressure with address wrap: 37 beats from 0x7FFFFC0.
    ar_stall = 5; rv_toggle = 1;
    ar_log_addr.delete(); ar_log_len.delete();
    b0 = beats_total;
    req(27'h7FFFFC0, 37, 0);
    wait_idle(2000, "bp_done");
    chk("bp_beats", 256'(beats_total - b0), 256'(37));
    chk("bp_nbursts", 256'(ar_log_addr.size()), 256'(3));
    if (ar_log_addr.size() == 3) begin
      chk("bp_ar1_wrap", 256'(ar_log_addr[1]), 256'(27'h40));
      chk("bp_ar2_addr", 256'(ar_log_addr[2]), 256'(27'hC0));
      chk("bp_ar2_len", 256'(ar_log_len[2]), 256'(4));
    end
    ar_stall = 0; rv_toggle = 0;

    // Queueing: second request pends, third overflows.
    chk("q_ovf_before", 256'(err_ovf), 256'(0));
    d0 = rdone_cnt;
    req(27'h2000, 40, 0);
    @(posedge clk); #1;
    req(27'h3000, 20, 0);
    req(27'h5000, 8, 1);
    chk("q_ovf_set", 256'(err_ovf), 256'(1));
    wait_idle(2000, "q_done");
    chk("q_rdones", 256'(rdone_cnt - d0), 256'(2));
    chk("q_ovf_sticky", 256'(err_ovf), 256'(1));

    // Protocol: early rlast on beat 10 of a 16-beat burst.
    chk("rl_before", 256'(err_rl), 256'(0));
    bad_rlast = 9;
    b0 = beats_total;
    req(27'h300, 16, 0);
    wait_idle(500, "rl_done");
    bad_rlast = -1;
    chk("rl_set", 256'(err_rl), 256'(1));
    chk("rl_beats", 256'(beats_total - b0), 256'(16));

    // Asynchronous reset mid-burst, then a fresh request.
    req(27'h4000, 64, 0);
    repeat (20) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("ar_rst_en", 256'(rdata_en), 256'(0));
    chk("ar_rst_busy", 256'(busy), 256'(0));
    chk("ar_rst_arvalid", 256'(arvalid), 256'(0));
    chk("ar_rst_rready", 256'(rready), 256'(0));
    chk("ar_rst_rdata", rdata, 256'(0));
    chk("ar_rst_flags", 256'({err_ovf, err_rl}), 256'(0));
    d0 = rdone_cnt;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("ar_no_rdone", 256'(rdone_cnt - d0), 256'(0));
    req(27'h5000, 20, 0);
    wait_idle(500, "post_rst_done");
    chk("post_rst_rdones", 256'(rdone_cnt - d0), 256'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
